// File: rtl/bomb_map_writer.sv
// Write-side tile map client: places one bomb, runs its fuse on frame ticks, paints a
// cross-shaped blast into the map, holds it, then scrubs the blast back to empty.
module bomb_map_writer #(
    parameter int NUM_ROW    = 11,
    parameter int NUM_COL    = 19,
    parameter int DATA_WIDTH = 4,
    parameter int FUSE_TICKS = 120,
    parameter int HOLD_TICKS = 30,
    parameter int RADIUS     = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tick,
    input  logic                               place,
    input  logic [$clog2(NUM_ROW)-1:0]         place_row,
    input  logic [$clog2(NUM_COL)-1:0]         place_col,
    output logic                               place_ack,
    output logic                               place_nack,
    output logic                               busy,
    output logic                               blast_on,
    output logic                               done,
    output logic [$clog2(NUM_ROW*NUM_COL)-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               we,
    output logic [$clog2(NUM_ROW*NUM_COL)-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]              wr_data
);
    localparam int RW   = $clog2(NUM_ROW);
    localparam int CW   = $clog2(NUM_COL);
    localparam int AW   = $clog2(NUM_ROW*NUM_COL);
    localparam int KW   = $clog2(RADIUS+1);
    localparam int TMAX = (FUSE_TICKS > HOLD_TICKS) ? FUSE_TICKS : HOLD_TICKS;
    localparam int TW   = $clog2(TMAX+1);

    localparam logic [DATA_WIDTH-1:0] T_EMPTY = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] T_BRICK = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] T_BOMB  = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] T_BLAST = DATA_WIDTH'(4);

    // Scan position: the centre, then the four arms in a fixed order.
    localparam logic [2:0] ARM_C     = 3'd0;
    localparam logic [2:0] ARM_UP    = 3'd1;
    localparam logic [2:0] ARM_DOWN  = 3'd2;
    localparam logic [2:0] ARM_LEFT  = 3'd3;
    localparam logic [2:0] ARM_RIGHT = 3'd4;
    localparam logic [2:0] ARM_END   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_CHK_RD, S_CHK_WT, S_FUSE, S_SCAN, S_VIS_RD, S_VIS_WT, S_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          row_q, row_d;
    logic [CW-1:0]          col_q, col_d;
    logic [2:0]             arm_q, arm_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   clr_q, clr_d;
    logic [TW-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]          rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                   we_q, we_d, ack_q, ack_d, nack_q, nack_d;
    logic                   done_q, done_d, blast_q, blast_d, busy_q, busy_d;

    int                     t_row, t_col;
    logic                   tgt_ok, hit_wr, hit_go;
    logic [AW-1:0]          tgt_addr, centre_addr;
    logic [DATA_WIDTH-1:0]  hit_data;

    function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(r) * AW'(NUM_COL) + AW'(c);
    endfunction

    assign centre_addr = addr_of(row_q, col_q);

    always_comb begin
        t_row = int'(row_q);
        t_col = int'(col_q);
        case (arm_q)
            ARM_UP:    t_row = int'(row_q) - int'(k_q);
            ARM_DOWN:  t_row = int'(row_q) + int'(k_q);
            ARM_LEFT:  t_col = int'(col_q) - int'(k_q);
            ARM_RIGHT: t_col = int'(col_q) + int'(k_q);
            default: ;
        endcase
        tgt_ok   = (arm_q != ARM_END) && (t_row >= 0) && (t_row < NUM_ROW) &&
                   (t_col >= 0) && (t_col < NUM_COL);
        tgt_addr = addr_of(RW'(t_row), CW'(t_col));
    end

    // Blast pass stops at walls/bombs and after a brick; clear pass follows blast tiles only.
    always_comb begin
        hit_wr   = 1'b0;
        hit_go   = 1'b0;
        hit_data = T_BLAST;
        if (clr_q) begin
            hit_wr   = (rd_data == T_BLAST);
            hit_go   = hit_wr;
            hit_data = T_EMPTY;
        end else begin
            hit_go = (rd_data == T_EMPTY) || (rd_data == T_BLAST);
            hit_wr = hit_go || (rd_data == T_BRICK);
        end
    end

    // place is a request sampled only in S_IDLE; ack/nack are single-cycle responses to it.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        arm_d     = arm_q;
        k_d       = k_q;
        clr_d     = clr_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        we_d      = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        ack_d     = 1'b0;
        nack_d    = 1'b0;
        done_d    = 1'b0;
        blast_d   = blast_q;
        case (state_q)
            S_IDLE: if (place) begin
                if (int'(place_row) >= NUM_ROW || int'(place_col) >= NUM_COL) begin
                    nack_d = 1'b1;
                end else begin
                    row_d     = place_row;
                    col_d     = place_col;
                    rd_addr_d = addr_of(place_row, place_col);
                    state_d   = S_CHK_RD;
                end
            end
            S_CHK_RD: state_d = S_CHK_WT;
            S_CHK_WT: begin
                if (rd_data == T_EMPTY) begin
                    we_d      = 1'b1;
                    wr_addr_d = centre_addr;
                    wr_data_d = T_BOMB;
                    ack_d     = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_FUSE;
                end else begin
                    nack_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FUSE: if (tick && !ack_q) begin
                if (cnt_q == TW'(FUSE_TICKS - 1)) begin
                    we_d      = 1'b1;
                    wr_addr_d = centre_addr;
                    wr_data_d = T_BLAST;
                    blast_d   = 1'b1;
                    clr_d     = 1'b0;
                    arm_d     = ARM_UP;
                    k_d       = KW'(1);
                    cnt_d     = '0;
                    state_d   = S_SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SCAN: begin
                if (arm_q == ARM_END) begin
                    if (clr_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end
                end else if (tgt_ok) begin
                    rd_addr_d = tgt_addr;
                    state_d   = S_VIS_RD;
                end else begin
                    arm_d = arm_q + 3'd1;
                    k_d   = KW'(1);
                end
            end
            S_VIS_RD: state_d = S_VIS_WT;
            S_VIS_WT: begin
                if (hit_wr) begin
                    we_d      = 1'b1;
                    wr_addr_d = tgt_addr;
                    wr_data_d = hit_data;
                end
                if (hit_go && arm_q != ARM_C && k_q != KW'(RADIUS)) begin
                    k_d = k_q + 1'b1;
                end else begin
                    arm_d = arm_q + 3'd1;
                    k_d   = KW'(1);
                end
                state_d = S_SCAN;
            end
            S_HOLD: if (tick) begin
                if (cnt_q == TW'(HOLD_TICKS - 1)) begin
                    blast_d = 1'b0;
                    clr_d   = 1'b1;
                    arm_d   = ARM_C;
                    k_d     = KW'(1);
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            arm_q     <= ARM_C;
            k_q       <= '0;
            clr_q     <= 1'b0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            we_q      <= 1'b0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
            done_q    <= 1'b0;
            blast_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            arm_q     <= arm_d;
            k_q       <= k_d;
            clr_q     <= clr_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            we_q      <= we_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
            done_q    <= done_d;
            blast_q   <= blast_d;
            busy_q    <= busy_d;
        end
    end

    assign place_ack  = ack_q;
    assign place_nack = nack_q;
    assign busy       = busy_q;
    assign blast_on   = blast_q;
    assign done       = done_q;
    assign rd_addr    = rd_addr_q;
    assign we         = we_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
endmodule

// File: tb/tb_bomb_map_writer.sv
// Bench for bomb_map_writer: a behavioural tile map on the ports, a shadow map that predicts
// every write, and an ordered queue of expected {addr, data} writes.
module tb_bomb_map_writer;
  localparam int NR  = 11;
  localparam int NC  = 19;
  localparam int FT  = 3;
  localparam int HT  = 2;
  localparam int RAD = 2;
  localparam logic [3:0] T_EMPTY = 4'd0;
  localparam logic [3:0] T_WALL  = 4'd1;
  localparam logic [3:0] T_BRICK = 4'd2;
  localparam logic [3:0] T_BOMB  = 4'd3;
  localparam logic [3:0] T_BLAST = 4'd4;

  logic       clk, rst, tick, place;
  logic [3:0] place_row;
  logic [4:0] place_col;
  logic       place_ack, place_nack, busy, blast_on, done, we;
  logic [7:0] rd_addr, wr_addr;
  logic [3:0] rd_data, wr_data;

  logic [3:0]  mem [0:NR*NC-1];
  logic [3:0]  model_map [0:NR*NC-1];
  logic [11:0] exp_q [$];
  logic        tb_we, tb_clr;
  logic [7:0]  tb_addr;
  logic [3:0]  tb_data;

  int  n_tests = 0, n_fail = 0;
  int  ack_cnt = 0, nack_cnt = 0, done_cnt = 0, we_cnt = 0, bad_rd = 0;
  bit  mon_en = 0;
  logic prev_we = 1'b0;

  bomb_map_writer #(
    .NUM_ROW(NR), .NUM_COL(NC), .DATA_WIDTH(4),
    .FUSE_TICKS(FT), .HOLD_TICKS(HT), .RADIUS(RAD)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .place(place),
    .place_row(place_row), .place_col(place_col),
    .place_ack(place_ack), .place_nack(place_nack),
    .busy(busy), .blast_on(blast_on), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural map: synchronous read, one write port
  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (tb_clr) begin
      for (int i = 0; i < NR*NC; i++) mem[i] <= T_EMPTY;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (mon_en) begin
      logic [11:0] exp_w;
      if (place_ack) ack_cnt++;
      if (place_nack) nack_cnt++;
      if (done) done_cnt++;
      if (int'(rd_addr) >= NR*NC) bad_rd++;
      if (we) begin
        we_cnt++;
        check("we_gap", prev_we, 0);
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hfff;
        check("wr", {wr_addr, wr_data}, exp_w);
      end else begin
        check("wr_idle", {wr_addr, wr_data}, 0);
      end
      if (place_ack) check("ack_with_we", we, 1);
      prev_we = we;
    end
  end

  function automatic int idx(input int r, input int c);
    return r * NC + c;
  endfunction

  task automatic push_wr(input int a, input logic [3:0] d);
    model_map[a] = d;
    exp_q.push_back({8'(a), d});
  endtask

  task automatic push_blast(input int r, input int c);
    int dr [4];
    int dc [4];
    dr = '{-1, 1, 0, 0};
    dc = '{0, 0, -1, 1};
    push_wr(idx(r, c), T_BLAST);
    for (int a = 0; a < 4; a++) begin
      for (int k = 1; k <= RAD; k++) begin
        int rr, cc;
        logic [3:0] t;
        rr = r + dr[a] * k;
        cc = c + dc[a] * k;
        if (rr < 0 || rr >= NR || cc < 0 || cc >= NC) break;
        t = model_map[idx(rr, cc)];
        if (t == T_EMPTY || t == T_BLAST) begin
          push_wr(idx(rr, cc), T_BLAST);
        end else if (t == T_BRICK) begin
          push_wr(idx(rr, cc), T_BLAST);
          break;
        end else begin
          break;
        end
      end
    end
  endtask

  task automatic push_clear(input int r, input int c);
    int dr [4];
    int dc [4];
    dr = '{-1, 1, 0, 0};
    dc = '{0, 0, -1, 1};
    if (model_map[idx(r, c)] == T_BLAST) push_wr(idx(r, c), T_EMPTY);
    for (int a = 0; a < 4; a++) begin
      for (int k = 1; k <= RAD; k++) begin
        int rr, cc;
        rr = r + dr[a] * k;
        cc = c + dc[a] * k;
        if (rr < 0 || rr >= NR || cc < 0 || cc >= NC) break;
        if (model_map[idx(rr, cc)] != T_BLAST) break;
        push_wr(idx(rr, cc), T_EMPTY);
      end
    end
  endtask

  // driver tasks (called at posedge + 1)
  task automatic clear_map();
    tb_clr = 1'b1;
    @(posedge clk); #1;
    tb_clr = 1'b0;
    for (int i = 0; i < NR*NC; i++) model_map[i] = T_EMPTY;
  endtask

  task automatic set_tile(input int r, input int c, input logic [3:0] t);
    model_map[idx(r, c)] = t;
    tb_addr = 8'(idx(r, c));
    tb_data = t;
    tb_we = 1'b1;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic send_tick();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_place(input int r, input int c, output bit ok);
    int a0, n0;
    a0 = ack_cnt;
    n0 = nack_cnt;
    ok = (r < NR) && (c < NC);
    if (ok) ok = (model_map[idx(r, c)] == T_EMPTY);
    if (ok) push_wr(idx(r, c), T_BOMB);
    place = 1'b1;
    place_row = 4'(r);
    place_col = 5'(c);
    @(posedge clk); #1;
    place = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("place_ack", ack_cnt - a0, ok ? 1 : 0);
    check("place_nack", nack_cnt - n0, ok ? 0 : 1);
  endtask

  task automatic run_bomb(input int r, input int c, input int fuse_done);
    int d0, n;
    d0 = done_cnt;
    push_blast(r, c);
    push_clear(r, c);
    for (int i = fuse_done; i < FT; i++) begin
      send_tick();
      check("blast_on_fuse", blast_on, (i == FT - 1) ? 1 : 0);
    end
    repeat (60) @(posedge clk);
    #1;
    for (int i = 0; i < HT; i++) begin
      send_tick();
      check("blast_on_hold", blast_on, (i == HT - 1) ? 0 : 1);
    end
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_pulse", done_cnt - d0, 1);
    check("busy_after_done", busy, 0);
    check("exp_q_drained", exp_q.size(), 0);
    begin
      int m;
      m = 0;
      for (int i = 0; i < NR*NC; i++) if (mem[i] !== model_map[i]) m++;
      check("map_match", m, 0);
    end
  endtask

  initial begin
    bit ok;
    int w0, a0, n0;
    rst = 1'b1; tick = 1'b0; place = 1'b0; place_row = '0; place_col = '0;
    tb_we = 1'b0; tb_clr = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_blast_on", blast_on, 0);
    check("rst_we", we, 0);
    check("rst_ack_nack_done", {place_ack, place_nack, done}, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr", {wr_addr, wr_data}, 0);
    mon_en = 1;
    @(posedge clk); #1;
    clear_map();

    // exact place timing at (5,9); a tick in the ack cycle must not count
    model_map[104] = T_BOMB;
    exp_q.push_back({8'd104, T_BOMB});
    place = 1'b1; place_row = 4'd5; place_col = 5'd9;
    @(posedge clk); #1;
    place = 1'b0;
    @(negedge clk);
    check("rd_addr_n1", rd_addr, 104);
    check("busy_n1", busy, 1);
    check("ack_n1", place_ack, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ack_n2", place_ack, 0);
    @(posedge clk); #1;
    tick = 1'b1;
    @(negedge clk);
    check("ack_n3", place_ack, 1);
    check("we_n3", we, 1);
    check("wr_data_n3", wr_data, 3);
    check("wr_addr_n3", wr_addr, 104);
    @(posedge clk); #1;
    tick = 1'b0;
    run_bomb(5, 9, 0);

    // wall centre and off-map requests
    clear_map();
    set_tile(0, 0, T_WALL);
    w0 = we_cnt;
    do_place(0, 0, ok);
    check("wall_no_we", we_cnt - w0, 0);
    check("wall_busy", busy, 0);
    place = 1'b1; place_row = 4'd11; place_col = 5'd0;
    @(posedge clk); #1;
    place = 1'b0;
    @(negedge clk);
    check("nack_oor_row", place_nack, 1);
    check("busy_oor_row", busy, 0);
    @(posedge clk); #1;
    do_place(0, 19, ok);

    // brick/wall neighbours of (0,0); a request while busy is ignored
    clear_map();
    set_tile(0, 1, T_BRICK);
    set_tile(1, 0, T_WALL);
    do_place(0, 0, ok);
    send_tick();
    a0 = ack_cnt;
    n0 = nack_cnt;
    place = 1'b1; place_row = 4'd3; place_col = 5'd3;
    @(posedge clk); #1;
    place = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_place_ack", ack_cnt - a0, 0);
    check("busy_place_nack", nack_cnt - n0, 0);
    run_bomb(0, 0, 1);

    // bottom-right corner
    clear_map();
    do_place(10, 18, ok);
    run_bomb(10, 18, 0);
    check("corner_bad_rd", bad_rd, 0);

    // random maps with walls, bricks and foreign bombs
    for (int it = 0; it < 4; it++) begin
      int r, c;
      clear_map();
      for (int j = 0; j < 30; j++) begin
        set_tile($urandom_range(0, NR - 1), $urandom_range(0, NC - 1), 4'($urandom_range(1, 3)));
      end
      r = $urandom_range(0, NR);
      c = $urandom_range(0, NC);
      do_place(r, c, ok);
      if (ok) run_bomb(r, c, 0);
    end

    // reset in the middle of the arm scan
    clear_map();
    do_place(5, 5, ok);
    push_blast(5, 5);
    for (int i = 0; i < FT; i++) send_tick();
    check("pre_rst_blast_on", blast_on, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_we", we, 0);
    check("rst_mid_blast_on", blast_on, 0);
    @(posedge clk); #1;
    exp_q.delete();
    clear_map();
    do_place(2, 2, ok);
    run_bomb(2, 2, 0);

    check("bad_rd_total", bad_rd, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
